// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request channel and registered result channel.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_v
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_v
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags and a stored carry for ADC/SBC.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 9).
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpEor = 4'd4;
  localparam logic [3:0] OpAdc = 4'd5;
  localparam logic [3:0] OpSbc = 4'd6;
  localparam logic [3:0] OpShl = 4'd7;
  localparam logic [3:0] OpShr = 4'd8;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OpMul = 4'd9;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic             cst_q, cst_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [5:0]         cnt_q, cnt_d;
`endif

  // Shared adder: SUB/SBC add the inverted operand.
  always_comb begin
    b_op = ((bus.opcode == OpSub) || (bus.opcode == OpSbc)) ? ~bus.b : bus.b;
    cin  = 1'b0;
    if (bus.opcode == OpSub) begin
      cin = 1'b1;
    end else if ((bus.opcode == OpAdc) || (bus.opcode == OpSbc)) begin
      cin = cst_q;
    end
    sum = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.opcode)
      OpAdd, OpSub, OpAdc, OpSbc: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAnd: alu_res = bus.a & bus.b;
      OpOr:  alu_res = bus.a | bus.b;
      OpEor: alu_res = bus.a ^ bus.b;
      OpShl: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_c   = bus.a[WIDTH-1];
      end
      OpShr: begin
        alu_res = {1'b0, bus.a[WIDTH-1:1]};
        alu_c   = bus.a[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready = !rst && ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    accept   = bus.in_valid && in_ready;

    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    cst_d    = cst_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif

    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (bus.opcode == OpMul) begin
        state_d  = StBusy;
        mcand_d  = {{WIDTH{1'b0}}, bus.a};
        mplier_d = bus.b;
        acc_d    = '0;
        cnt_d    = '0;
      end else
`endif
      begin
        state_d  = StDone;
        result_d = alu_res;
        z_d      = ~|alu_res;
        c_d      = alu_c;
        n_d      = alu_res[WIDTH-1];
        v_d      = alu_v;
        cst_d    = alu_c;
      end
    end
`ifdef ALU_SEQ_MUL_EN
    else if (state_q == StBusy) begin
      // One multiplier bit per cycle; the full 2*WIDTH product feeds the carry flag.
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 6'd1;
      if (cnt_q == 6'(WIDTH - 1)) begin
        state_d  = StDone;
        result_d = acc_d[WIDTH-1:0];
        z_d      = ~|acc_d[WIDTH-1:0];
        c_d      = |acc_d[2*WIDTH-1:WIDTH];
        n_d      = acc_d[WIDTH-1];
        v_d      = 1'b0;
        cst_d    = |acc_d[2*WIDTH-1:WIDTH];
      end
    end
`endif
    else if ((state_q == StDone) && bus.out_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      cst_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      cst_q    <= cst_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic against a
// transaction-level reference model checked every cycle.
module tb_alu_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [W+3:0] word(input logic [W-1:0] r, input logic z, c, n, v);
    return {r, z, c, n, v};
  endfunction

  // Expected {result, Z, C, N, V} from the arithmetic definition of each opcode.
  function automatic logic [W+3:0] ref_op(input logic [3:0] op, input logic [W-1:0] av,
                                         input logic [W-1:0] bv, input logic cst);
    longint ua, ub, m, hi, lo, sa, sb, s, ss, res, c, v, cl, p;
    ua = longint'(av);
    ub = longint'(bv);
    cl = cst ? 1 : 0;
    m  = (longint'(1) << W) - 1;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    sa = (ua > hi) ? ua - (m + 1) : ua;
    sb = (ub > hi) ? ub - (m + 1) : ub;
    s = 0; ss = 0; res = 0; c = 0; v = 0; p = 0;
    case (op)
      4'd0: begin s = ua + ub;            ss = sa + sb;          end
      4'd1: begin s = ua + (~ub & m) + 1; ss = sa - sb;          end
      4'd5: begin s = ua + ub + cl;       ss = sa + sb + cl;     end
      4'd6: begin s = ua + (~ub & m) + cl; ss = sa - sb - 1 + cl; end
      4'd2: res = ua & ub;
      4'd3: res = ua | ub;
      4'd4: res = ua ^ ub;
      4'd7: begin res = (ua << 1) & m; c = (ua >> (W - 1)) & 1; end
      4'd8: begin res = ua >> 1;       c = ua & 1;             end
`ifdef ALU_SEQ_MUL_EN
      4'd9: begin p = ua * ub; res = p & m; c = ((p >> W) != 0) ? 1 : 0; end
`endif
      default: res = 0;
    endcase
    if (op inside {4'd0, 4'd1, 4'd5, 4'd6}) begin
      res = s & m;
      c   = (s >> W) & 1;
      v   = (ss > hi || ss < lo) ? 1 : 0;
    end
    return {res[W-1:0], (res == 0), c[0], res[W-1], v[0]};
  endfunction

  // Reference model: phase 0 idle, 1 multiplying, 2 holding a result.
  int             m_phase = 0;
  int             m_left  = 0;
  logic [W+3:0]   m_out   = '0;
  logic [W+3:0]   m_pend  = '0;
  logic           m_cst   = 1'b0;
  logic           m_rdy, m_acc, m_is_mul;
  logic [W+3:0]   m_new;

  always_comb begin
    m_rdy    = !rst && (m_phase == 0 || (m_phase == 2 && bus.out_ready));
    m_acc    = bus.in_valid && m_rdy;
`ifdef ALU_SEQ_MUL_EN
    m_is_mul = (bus.opcode == 4'd9);
`else
    m_is_mul = 1'b0;
`endif
    m_new    = ref_op(bus.opcode, bus.a, bus.b, m_cst);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_out   <= '0;
      m_cst   <= 1'b0;
    end else if (m_acc) begin
      if (m_is_mul) begin
        m_phase <= 1;
        m_left  <= W;
        m_pend  <= m_new;
      end else begin
        m_phase <= 2;
        m_out   <= m_new;
        m_cst   <= m_new[2];
      end
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_phase <= 2;
        m_out   <= m_pend;
        m_cst   <= m_pend[2];
      end
    end else if (m_phase == 2 && bus.out_ready) begin
      m_phase <= 0;
    end
  end

  logic [W+3:0] dut_word;
  assign dut_word = {bus.result, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v};

  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_rdy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_phase == 2));
      if (m_phase == 2) chk("result_flags", 64'(dut_word), 64'(m_out));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ordy);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = aa;
    bus.b         = bb;
    bus.opcode    = op;
    bus.out_ready = ordy;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #3;
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    started = 1'b1;
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_word", 64'(dut_word), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(4'd0, 8'hFF, 8'h01, 1'b1);
    chk("add_ff_01_valid", 64'(bus.out_valid), 64'd1);
    chk("add_ff_01", 64'(dut_word), 64'(word(8'h00, 1, 1, 0, 0)));
    issue(4'd0, 8'h7F, 8'h01, 1'b1);
    chk("add_7f_01", 64'(dut_word), 64'(word(8'h80, 0, 0, 1, 1)));
    issue(4'd1, 8'h05, 8'h07, 1'b1);
    chk("sub_05_07", 64'(dut_word), 64'(word(8'hFE, 0, 0, 1, 0)));
    issue(4'd0, 8'hFF, 8'h01, 1'b1);
    issue(4'd5, 8'h10, 8'h20, 1'b1);
    chk("adc_b2b", 64'(dut_word), 64'(word(8'h31, 0, 0, 0, 0)));

`ifdef ALU_SEQ_MUL_EN
    issue(4'd9, 8'h0F, 8'h11, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      chk("mul_busy_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      #3;
      n++;
    end
    chk("mul_latency", 64'(n), 64'(W));
    chk("mul_0f_11", 64'(dut_word), 64'(word(8'hFF, 0, 0, 1, 0)));
    issue(4'd9, 8'h10, 8'h10, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("mul_10_10", 64'(dut_word), 64'(word(8'h00, 1, 1, 0, 0)));
`else
    issue(4'd9, 8'h03, 8'h03, 1'b1);
    chk("op9_disabled_valid", 64'(bus.out_valid), 64'd1);
    chk("op9_disabled", 64'(dut_word), 64'(word(8'h00, 1, 0, 0, 0)));
`endif

    issue(4'd7, 8'h81, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("shl_hold", 64'(dut_word), 64'(word(8'h02, 0, 1, 0, 0)));
      chk("shl_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("shl_hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      #3;
    end
    bus.out_ready = 1'b1;

    // Abort an op in flight; the carry left by SHL must not reach the following ADC.
    issue(4'd9, 8'h0F, 8'h11, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_abort_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_abort_word", 64'(dut_word), 64'd0);
    issue(4'd5, 8'h01, 8'h01, 1'b1);
    chk("adc_after_rst", 64'(dut_word), 64'(word(8'h02, 0, 0, 0, 0)));

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 99) == 0);
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      if ($urandom_range(0, 3) == 0) bus.a = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h7F;
      if ($urandom_range(0, 3) == 0) bus.b = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h01;
      bus.opcode    = ($urandom_range(0, 4) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      bus.out_ready = $urandom_range(0, 9) < 7;
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port opcode  input  4  operation select.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports flag_z, flag_c, flag_n, flag_v  output  1 each  registered zero/carry/negative/overflow flags.

Function
REQ-013 SHALL accept a request (capture a, b, opcode) on a cycle where in_valid and in_ready are both high.
REQ-014 SHALL implement states IDLE, BUSY, DONE; IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting MUL; BUSY->DONE after WIDTH iterations; DONE->IDLE on out_ready with no new accept.
REQ-015 SHALL drive in_ready high in IDLE, and in DONE when out_ready is high (back-to-back accept, next state per REQ-014 from the new opcode); low in BUSY and while rst is high.
REQ-016 SHALL drive out_valid high only in DONE; result and flags SHALL hold stable while out_valid is high and out_ready is low.
REQ-017 Single-cycle ops SHALL assert out_valid on the cycle after acceptance (latency 1).
REQ-018 Opcodes: 0 ADD a+b; 1 SUB a-b (a+~b+1); 2 AND; 3 OR; 4 EOR; 5 ADC a+b+Cst; 6 SBC a+~b+Cst; 7 SHL a<<1; 8 SHR logical a>>1; 9 MUL low WIDTH bits of a*b.
REQ-019 Cst SHALL be an internal stored carry, updated to flag_c on each completed op; ADC/SBC SHALL use Cst as of the accepting cycle, including on a back-to-back accept (use the value just produced).
REQ-020 Flags: Z = result all-zero; N = result MSB; C = adder carry-out for 0,1,5,6 (SUB: 1 = no borrow), bit shifted out for 7/8, 1 if upper WIDTH product bits nonzero for 9, else 0; V = signed overflow for 0,1,5,6, else 0.
REQ-021 MUL SHALL be iterative shift-add, one bit per cycle, out_valid on cycle T+WIDTH+1 for acceptance at T.
REQ-022 Opcodes 10-15 SHALL complete as single-cycle ops with result 0, Z=1, C=N=V=0, Cst cleared.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH; no X SHALL appear on any output.

Reset
REQ-024 On rst high at a clock edge: state IDLE, out_valid=0, result=0, all flags 0, Cst=0, MUL iteration state cleared; this SHALL abort any op in BUSY or DONE, result discarded.
REQ-025 Requests presented while rst is high SHALL be ignored.

Configuration
REQ-026 Macro ALU_SEQ_MUL_EN defined: opcode 9 SHALL behave per REQ-018/021; undefined: opcode 9 SHALL behave per REQ-022, BUSY state and multiplier logic SHALL not be synthesised.

Verification (WIDTH=8)
REQ-027 ADD a=0xFF b=0x01 -> next cycle out_valid=1, result=0x00, Z=1 C=1 N=0 V=0.
REQ-028 ADD 0x7F+0x01 -> result 0x80, N=1 V=1 C=0; then SUB 0x05-0x07 -> 0xFE, C=0 N=1.
REQ-029 ADD 0xFF+0x01 (C=1) then back-to-back ADC 0x10+0x20 with out_ready=1 -> second result 0x31, C=0.
REQ-030 MUL 0x0F*0x11 -> out_valid 9 cycles after accept, result 0xFF C=0; MUL 0x10*0x10 -> 0x00, Z=1 C=1; in_ready=0 throughout BUSY.
REQ-031 out_ready low 3 cycles after SHL 0x81 -> result 0x02 C=1 stable, in_ready=0; rst pulse mid-MUL -> next cycle out_valid=0, flags 0, following ADC 0x01+0x01 gives 0x02.
REQ-032 ALU_SEQ_MUL_EN undefined: opcode 9 with a=0x03 b=0x03 -> latency 1, result 0x00, Z=1.
